// File: rtl/sensor_monitor.sv
// Debounced sensor fault monitor: qualifies a combinational fault condition over DEBOUNCE
// consecutive cycles, latches it until acknowledged, and records entry count and snapshot.
module sensor_monitor #(
  parameter int unsigned NUM_SENSORS = 4,
  parameter int unsigned DEBOUNCE    = 3,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NUM_SENSORS-1:0] sensors,
  input  logic                   clear,
  output logic                   error,
  output logic                   error_pulse,
  output logic [CNT_WIDTH-1:0]   err_count,
  output logic [NUM_SENSORS-1:0] snapshot
);

  localparam int unsigned DbW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {StIdle, StPending, StFault} state_e;

  state_e                 state_q, state_d;
  logic [DbW-1:0]         cnt_q, cnt_d;
  logic                   pulse_q;
  logic [CNT_WIDTH-1:0]   err_count_q;
  logic [NUM_SENSORS-1:0] snapshot_q;
  logic                   raw_fault;
  logic                   enter_fault;

  // Gate line only counts together with at least one secondary line.
  assign raw_fault = sensors[0] | (sensors[1] & (|sensors[NUM_SENSORS-1:2]));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    enter_fault = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (raw_fault) begin
          if (DEBOUNCE == 1) begin
            state_d     = StFault;
            enter_fault = 1'b1;
          end else begin
            state_d = StPending;
            cnt_d   = DbW'(1);
          end
        end
      end
      StPending: begin
        if (!raw_fault) begin
          state_d = StIdle;
        end else if (cnt_q == DbLast) begin
          state_d     = StFault;
          enter_fault = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFault: begin
        // Acknowledge only takes effect once the fault condition has gone away.
        if (clear && !raw_fault) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pulse_q     <= 1'b0;
      err_count_q <= '0;
      snapshot_q  <= '0;
    end else begin
      pulse_q <= enter_fault;
      if (enter_fault) begin
        snapshot_q <= sensors;
        if (err_count_q != {CNT_WIDTH{1'b1}}) begin
          err_count_q <= err_count_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    error       = (state_q == StFault);
    error_pulse = pulse_q;
    err_count   = err_count_q;
    snapshot    = snapshot_q;
  end

endmodule

// File: tb/tb_sensor_monitor.sv
// Directed self-checking bench for sensor_monitor: default, narrow-counter and
// single-cycle-debounce instances share the same stimulus.
module tb_sensor_monitor;

  logic       clk;
  logic       n_rst;
  logic [3:0] sensors;
  logic       clear;

  logic       err_d, pls_d;
  logic [7:0] cnt_d;
  logic [3:0] snap_d;
  logic       err_c, pls_c;
  logic [1:0] cnt_c;
  logic [3:0] snap_c;
  logic       err_1, pls_1;
  logic [7:0] cnt_1;
  logic [3:0] snap_1;

  int errors = 0;
  int checks = 0;

  sensor_monitor u_def (
    .clk(clk), .n_rst(n_rst), .sensors(sensors), .clear(clear),
    .error(err_d), .error_pulse(pls_d), .err_count(cnt_d), .snapshot(snap_d)
  );

  sensor_monitor #(.CNT_WIDTH(2)) u_cw2 (
    .clk(clk), .n_rst(n_rst), .sensors(sensors), .clear(clear),
    .error(err_c), .error_pulse(pls_c), .err_count(cnt_c), .snapshot(snap_c)
  );

  sensor_monitor #(.DEBOUNCE(1)) u_db1 (
    .clk(clk), .n_rst(n_rst), .sensors(sensors), .clear(clear),
    .error(err_1), .error_pulse(pls_1), .err_count(cnt_1), .snapshot(snap_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sensors = 4'b0000;
    clear   = 1'b0;
    n_rst   = 1'b0;
    step();
    step();
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b1; sensors = 4'b0000; clear = 1'b0;
    #3 n_rst = 1'b0;
    #1;
    checks++; if (err_d !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", err_d); end
    checks++; if (pls_d !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", pls_d); end
    checks++; if (cnt_d !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt_d); end
    checks++; if (snap_d !== 4'b0000) begin errors++; $display("FAIL reset_snapshot got %b want 0000", snap_d); end
    checks++; if ({err_c, pls_c, cnt_c, snap_c} !== 8'd0) begin errors++; $display("FAIL reset_cw2 got %b want 0", {err_c, pls_c, cnt_c, snap_c}); end
    checks++; if ({err_1, pls_1, cnt_1, snap_1} !== 14'd0) begin errors++; $display("FAIL reset_db1 got %b want 0", {err_1, pls_1, cnt_1, snap_1}); end
    step();
    n_rst = 1'b1;
  endtask

  // Three edges of critical fault, then acknowledge behaviour.
  task automatic test_basic_and_clear();
    do_reset();
    sensors = 4'b0001;
    step();
    checks++; if (err_d !== 1'b0) begin errors++; $display("FAIL basic_edge1 got %b want 0", err_d); end
    step();
    checks++; if (err_d !== 1'b0) begin errors++; $display("FAIL basic_edge2 got %b want 0", err_d); end
    step();
    checks++; if (err_d !== 1'b1) begin errors++; $display("FAIL basic_edge3_error got %b want 1", err_d); end
    checks++; if (pls_d !== 1'b1) begin errors++; $display("FAIL basic_edge3_pulse got %b want 1", pls_d); end
    checks++; if (cnt_d !== 8'd1) begin errors++; $display("FAIL basic_count got %0d want 1", cnt_d); end
    checks++; if (snap_d !== 4'b0001) begin errors++; $display("FAIL basic_snapshot got %b want 0001", snap_d); end
    step();
    checks++; if (pls_d !== 1'b0) begin errors++; $display("FAIL basic_edge4_pulse got %b want 0", pls_d); end
    checks++; if (err_d !== 1'b1) begin errors++; $display("FAIL basic_edge4_error got %b want 1", err_d); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (err_d !== 1'b1) begin errors++; $display("FAIL clear_while_raw got %b want 1", err_d); end
    sensors = 4'b0000;
    step();
    checks++; if (err_d !== 1'b1) begin errors++; $display("FAIL clear_not_remembered got %b want 1", err_d); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (err_d !== 1'b0) begin errors++; $display("FAIL clear_accepted got %b want 0", err_d); end
    checks++; if (cnt_d !== 8'd1) begin errors++; $display("FAIL clear_count got %0d want 1", cnt_d); end
    checks++; if (snap_d !== 4'b0001) begin errors++; $display("FAIL clear_snapshot got %b want 0001", snap_d); end
  endtask

  // After clearing, a fresh full run is needed for the next pulse.
  task automatic test_back_to_back();
    sensors = 4'b0001;
    step();
    checks++; if (err_d !== 1'b0) begin errors++; $display("FAIL b2b_edge1 got %b want 0", err_d); end
    step();
    checks++; if (err_d !== 1'b0) begin errors++; $display("FAIL b2b_edge2 got %b want 0", err_d); end
    step();
    checks++; if ({err_d, pls_d} !== 2'b11) begin errors++; $display("FAIL b2b_edge3 got %b want 11", {err_d, pls_d}); end
    checks++; if (cnt_d !== 8'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", cnt_d); end
  endtask

  task automatic test_glitch();
    do_reset();
    sensors = 4'b0110;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (err_d !== 1'b0) begin errors++; $display("FAIL glitch_0110_%0d got %b want 0", i, err_d); end
    end
    sensors = 4'b0010;
    step();
    checks++; if (err_d !== 1'b0) begin errors++; $display("FAIL glitch_0010 got %b want 0", err_d); end
    sensors = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (err_d !== 1'b0) begin errors++; $display("FAIL glitch_1010_%0d got %b want 0", i, err_d); end
    end
    step();
    checks++; if ({err_d, pls_d} !== 2'b11) begin errors++; $display("FAIL glitch_fault got %b want 11", {err_d, pls_d}); end
    checks++; if (snap_d !== 4'b1010) begin errors++; $display("FAIL glitch_snapshot got %b want 1010", snap_d); end
  endtask

  // Clear during PENDING must not disturb the running count.
  task automatic test_clear_in_pending();
    do_reset();
    clear = 1'b1;
    step();
    checks++; if ({err_d, cnt_d} !== 9'd0) begin errors++; $display("FAIL idle_clear got %h want 0", {err_d, cnt_d}); end
    sensors = 4'b0001;
    step();
    step();
    clear = 1'b0;
    step();
    checks++; if (err_d !== 1'b1) begin errors++; $display("FAIL pending_clear got %b want 1", err_d); end
  endtask

  task automatic test_saturate();
    int exp_cnt[5] = '{1, 2, 3, 3, 3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      sensors = 4'b0001;
      step(); step(); step();
      checks++; if (cnt_c !== 2'(exp_cnt[k])) begin errors++; $display("FAIL sat_count_%0d got %0d want %0d", k, cnt_c, exp_cnt[k]); end
      sensors = 4'b0000;
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++; if (err_c !== 1'b0) begin errors++; $display("FAIL sat_clear_%0d got %b want 0", k, err_c); end
    end
  endtask

  task automatic test_debounce1();
    do_reset();
    sensors = 4'b0011;
    step();
    checks++; if ({err_1, pls_1} !== 2'b11) begin errors++; $display("FAIL db1_fault got %b want 11", {err_1, pls_1}); end
    checks++; if (snap_1 !== 4'b0011) begin errors++; $display("FAIL db1_snapshot got %b want 0011", snap_1); end
    checks++; if (cnt_1 !== 8'd1) begin errors++; $display("FAIL db1_count got %0d want 1", cnt_1); end
    step();
    checks++; if ({err_1, pls_1} !== 2'b10) begin errors++; $display("FAIL db1_after got %b want 10", {err_1, pls_1}); end
  endtask

  task automatic test_async_reset();
    do_reset();
    sensors = 4'b0001;
    step(); step(); step();
    checks++; if (err_d !== 1'b1) begin errors++; $display("FAIL ar_setup got %b want 1", err_d); end
    #2 n_rst = 1'b0;
    #1;
    checks++; if ({err_d, pls_d, cnt_d, snap_d} !== 14'd0) begin errors++; $display("FAIL ar_fault got %h want 0", {err_d, pls_d, cnt_d, snap_d}); end
    #2 n_rst = 1'b1;
    step(); step();
    checks++; if ({err_d, pls_d} !== 2'b00) begin errors++; $display("FAIL ar_fault_rerun got %b want 00", {err_d, pls_d}); end
    // Now in PENDING with two credits; reset must discard them.
    #2 n_rst = 1'b0;
    #1;
    checks++; if ({err_d, pls_d, cnt_d, snap_d} !== 14'd0) begin errors++; $display("FAIL ar_pending got %h want 0", {err_d, pls_d, cnt_d, snap_d}); end
    #2 n_rst = 1'b1;
    step(); step();
    checks++; if ({err_d, pls_d, cnt_d} !== 10'd0) begin errors++; $display("FAIL ar_pending_rerun got %h want 0", {err_d, pls_d, cnt_d}); end
    step();
    checks++; if ({err_d, pls_d} !== 2'b11) begin errors++; $display("FAIL ar_resume got %b want 11", {err_d, pls_d}); end
  endtask

  initial begin
    test_reset();
    test_basic_and_clear();
    test_back_to_back();
    test_glitch();
    test_clear_in_pending();
    test_saturate();
    test_debounce1();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sensor_monitor.md
SENSOR_MONITOR -- requirements
Module: sensor_monitor

Interface
REQ-001 SHALL have parameter NUM_SENSORS, default 4: sensor line count; legal range 3..32.
REQ-002 SHALL have parameter DEBOUNCE, default 3: consecutive faulty cycles required to declare an error; legal range 1..255.
REQ-003 SHALL have parameter CNT_WIDTH, default 8: error event counter width; legal range 1..16.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sensors  input  NUM_SENSORS  sensor lines, synchronous to clk; bit 0 critical, bit 1 gate, bits 2..N-1 secondary.
REQ-007 SHALL have port clear  input  1  single-cycle acknowledge of a latched error.
REQ-008 SHALL have port error  output  1  registered debounced error level.
REQ-009 SHALL have port error_pulse  output  1  one-cycle strobe on entry to the fault state.
REQ-010 SHALL have port err_count  output  CNT_WIDTH  saturating count of fault entries.
REQ-011 SHALL have port snapshot  output  NUM_SENSORS  sensors value captured at the most recent fault entry.

Function
REQ-012 SHALL compute raw_fault combinationally: sensors[0] OR (sensors[1] AND OR-reduce(sensors[NUM_SENSORS-1:2])).
REQ-013 SHALL implement a three-state FSM: IDLE, PENDING, FAULT.
REQ-014 SHALL keep a consecutive-cycle counter sized to hold DEBOUNCE, cleared to 0 in IDLE.
REQ-015 SHALL, in IDLE with raw_fault=1, enter FAULT directly when DEBOUNCE=1, else enter PENDING with counter=1.
REQ-016 SHALL, in PENDING with raw_fault=0, return to IDLE and clear the counter (no partial credit retained).
REQ-017 SHALL, in PENDING with raw_fault=1, enter FAULT when counter=DEBOUNCE-1, else increment the counter.
REQ-018 SHALL therefore set error high immediately after the DEBOUNCE-th consecutive rising edge sampling raw_fault=1.
REQ-019 SHALL drive error=1 exactly while the FSM is in FAULT.
REQ-020 SHALL, on the edge entering FAULT: assert error_pulse for exactly one cycle, load snapshot with sensors sampled at that edge, and increment err_count.
REQ-021 SHALL saturate err_count at all-ones; no wrap to zero.
REQ-022 SHALL, in FAULT, return to IDLE only on an edge with clear=1 AND raw_fault=0; error drops right after that edge.
REQ-023 SHALL ignore clear while raw_fault=1; the request is not remembered and must be re-issued.
REQ-024 SHALL ignore clear in IDLE and PENDING; state, counter, snapshot and err_count are unaffected.
REQ-025 SHALL never clear err_count or snapshot except by reset; snapshot holds until the next fault entry.
REQ-026 SHALL require a full new DEBOUNCE run after leaving FAULT before error can re-assert; no back-to-back pulse without passing through IDLE.

Reset
REQ-027 SHALL, on n_rst=0, immediately (without waiting for a clock edge) force state IDLE, counter 0, error 0, error_pulse 0, err_count 0, snapshot 0.
REQ-028 SHALL abandon any PENDING run or latched FAULT when reset is asserted mid-operation, with no pulse or count generated.
REQ-029 SHALL resume normal operation at the first rising edge after n_rst deasserts.

Verification
REQ-030 Defaults; sensors=4'b0001 held for 3 edges -> error=1 and error_pulse=1 after edge 3, err_count=1, snapshot=4'b0001; error_pulse=0 after edge 4.
REQ-031 Defaults; sensors=4'b0110 for 2 edges, then 4'b0010 for 1 edge, then 4'b1010 for 3 edges -> error stays 0 through the glitch, rises only after the 3rd edge of 4'b1010.
REQ-032 In FAULT with sensors=4'b0001, pulse clear -> error stays 1; set sensors=0, pulse clear -> error=0 after that edge, err_count unchanged.
REQ-033 CNT_WIDTH=2; force 5 fault/clear cycles -> err_count reads 1,2,3,3,3.
REQ-034 DEBOUNCE=1; sensors=4'b0011 for one edge -> error=1 after that single edge, error_pulse one cycle.
REQ-035 Assert n_rst=0 mid-PENDING and mid-FAULT between clock edges -> all outputs 0 at once; after release, 2 faulty edges produce no error (DEBOUNCE=3).
